// File: rtl/traffic_phase_controller_n_pkg.sv
// Shared definitions for the N-approach traffic phase controller.
// Holds the one-hot lamp encodings and the controller state encoding.
// The legacy four-way controller and the bench monitors use the same values.
package traffic_phase_controller_n_pkg;

    // One-hot lamp encodings per approach: {red, yellow, green}
    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    typedef enum logic [2:0] {
        ST_ALL_RED    = 3'd0,
        ST_GREEN      = 3'd1,
        ST_YELLOW     = 3'd2,
        ST_PRE_CLR    = 3'd3,
        ST_PRE_ALLRED = 3'd4,
        ST_PRE_GREEN  = 3'd5,
        ST_PRE_EXIT   = 3'd6
    } tlc_state_e;

    // States in which the active approach shows GREEN
    function automatic logic is_green_state(input tlc_state_e s);
        return (s == ST_GREEN) || (s == ST_PRE_GREEN);
    endfunction

    // States in which the active approach shows YELLOW
    function automatic logic is_yellow_state(input tlc_state_e s);
        return (s == ST_YELLOW) || (s == ST_PRE_CLR) || (s == ST_PRE_EXIT);
    endfunction

endpackage

// File: rtl/traffic_phase_controller_n_if.sv
// Sensor/lamp-side bundle of the traffic phase controller.
//   density        : per-approach density, approach i at [i*DENS_W +: DENS_W]
//   amb_req        : per-approach level ambulance request
//   lights         : per-approach lamp, approach i at [3i +: 3]
//   active_appr    : approach owning green/yellow
//   emergency_mode : preemption sequence in progress
//   phase_start    : pulse on first cycle of every green phase
// master = sensor/lamp-driver side, slave = controller side.
interface traffic_phase_controller_n_if
    import traffic_phase_controller_n_pkg::*;
#(
    parameter int N_APPR = 4,
    parameter int DENS_W = 4
);
    localparam int AW = $clog2(N_APPR);

    logic [N_APPR*DENS_W-1:0] density;
    logic [N_APPR-1:0]        amb_req;
    logic [3*N_APPR-1:0]      lights;
    logic [AW-1:0]            active_appr;
    logic                     emergency_mode;
    logic                     phase_start;

    modport master (
        output density, amb_req,
        input  lights, active_appr, emergency_mode, phase_start
    );

    modport slave (
        input  density, amb_req,
        output lights, active_appr, emergency_mode, phase_start
    );
endinterface

// File: rtl/traffic_phase_controller_n_tlc_next_appr.sv
// Combinational round-robin approach selector.
//   start      : index the scan is relative to
//   demand     : per-approach "wants service" flags
//   skip_empty : 1 = honour demand, 0 = plain successor
//   inclusive  : 1 = scan begins at start, 0 = at start+1 (mod N_APPR)
//   next_idx   : first demanded index in scan order; falls back to the
//                scan's first index when nothing is demanded or skipping is off
module tlc_next_appr
    import traffic_phase_controller_n_pkg::*;
#(
    parameter int N_APPR = 4,
    parameter int AW     = 2
) (
    input  logic [AW-1:0]     start,
    input  logic [N_APPR-1:0] demand,
    input  logic              skip_empty,
    input  logic              inclusive,
    output logic [AW-1:0]     next_idx
);

    logic [AW-1:0] base;
    logic [AW-1:0] idx;
    logic [AW-1:0] hit;
    logic          found;

    always_comb begin
        if (inclusive) begin
            base = start;
        end else if (start >= AW'(N_APPR - 1)) begin
            base = '0;
        end else begin
            base = start + AW'(1);
        end

        hit   = base;
        found = 1'b0;
        idx   = base;
        for (int unsigned k = 0; k < N_APPR; k++) begin
            idx = AW'((32'(base) + k) % N_APPR);
            if (!found && demand[idx]) begin
                hit   = idx;
                found = 1'b1;
            end
        end

        next_idx = (skip_empty && found) ? hit : base;
    end

endmodule

// File: rtl/traffic_phase_controller_n.sv
// N-approach adaptive traffic-signal controller with ambulance preemption
// and density-based phase skipping.
//   clk   : clock
//   rst_a : asynchronous active-high reset
//   bus   : slave side of traffic_phase_controller_n_if (density, amb_req in;
//           lights, active_appr, emergency_mode, phase_start out)
// Green time is computed from the selected approach's density when GREEN is
// entered and held for the whole phase. Every hand-over goes through all-red.
module traffic_phase_controller_n
    import traffic_phase_controller_n_pkg::*;
#(
    parameter int N_APPR       = 4,
    parameter int DENS_W       = 4,
    parameter int CNT_W        = 6,
    parameter int MIN_GREEN    = 4,
    parameter int MAX_GREEN    = 12,
    parameter int YELLOW_TIME  = 4,
    parameter int ALL_RED_TIME = 2,
    parameter int PREEMPT_CLR  = 3,
    parameter int SKIP_EMPTY   = 1
) (
    input logic clk,
    input logic rst_a,
    traffic_phase_controller_n_if.slave bus
);

    localparam int AW     = $clog2(N_APPR);
    localparam int DMAX   = (1 << DENS_W) - 1;
    localparam int PROD_W = DENS_W + CNT_W;

    tlc_state_e         state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   green_len_q, green_len_d;
    logic [AW-1:0]      active_q, active_d;
    logic [AW-1:0]      amb_idx_q, amb_idx_d;
    logic               emerg_q, emerg_d;
    logic               exit_q, exit_d;
    logic               phase_start_q, phase_start_d;

    logic [N_APPR-1:0]   dens_nz;
    logic [AW-1:0]       norm_next;
    logic [AW-1:0]       amb_sel;
    logic                amb_any;
    logic [DENS_W-1:0]   sel_dens;
    logic [PROD_W-1:0]   green_prod;
    logic [CNT_W-1:0]    green_calc;
    logic [3*N_APPR-1:0] lights;

    always_comb begin
        dens_nz = '0;
        for (int unsigned i = 0; i < N_APPR; i++) begin
            dens_nz[i] = |bus.density[i*DENS_W +: DENS_W];
        end
    end

    assign amb_any = |bus.amb_req;

    // Normal successor of the current approach
    tlc_next_appr #(
        .N_APPR (N_APPR),
        .AW     (AW)
    ) u_norm_sel (
        .start      (active_q),
        .demand     (dens_nz),
        .skip_empty (SKIP_EMPTY != 0),
        .inclusive  (1'b0),
        .next_idx   (norm_next)
    );

    // Same selector as a lowest-index priority encoder over the requests
    tlc_next_appr #(
        .N_APPR (N_APPR),
        .AW     (AW)
    ) u_amb_sel (
        .start      (AW'(0)),
        .demand     (bus.amb_req),
        .skip_empty (1'b1),
        .inclusive  (1'b1),
        .next_idx   (amb_sel)
    );

    // Green length for the approach about to be entered
    always_comb begin
        sel_dens   = bus.density[int'(norm_next)*DENS_W +: DENS_W];
        green_prod = PROD_W'(MAX_GREEN - MIN_GREEN) * PROD_W'(sel_dens);
        green_calc = CNT_W'(MIN_GREEN) + CNT_W'(green_prod / PROD_W'(DMAX));
    end

    // State register
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state_q       <= ST_ALL_RED;
            timer_q       <= '0;
            green_len_q   <= '0;
            active_q      <= AW'(N_APPR - 1);
            amb_idx_q     <= '0;
            emerg_q       <= 1'b0;
            exit_q        <= 1'b0;
            phase_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            green_len_q   <= green_len_d;
            active_q      <= active_d;
            amb_idx_q     <= amb_idx_d;
            emerg_q       <= emerg_d;
            exit_q        <= exit_d;
            phase_start_q <= phase_start_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + CNT_W'(1);
        green_len_d = green_len_q;
        active_d    = active_q;
        amb_idx_d   = amb_idx_q;
        emerg_d     = emerg_q;
        exit_d      = exit_q;

        if (!emerg_q && amb_any &&
            (state_q == ST_ALL_RED || state_q == ST_GREEN || state_q == ST_YELLOW)) begin
            amb_idx_d = amb_sel;
            emerg_d   = 1'b1;
            exit_d    = 1'b0;
            timer_d   = '0;
            if (state_q == ST_GREEN && active_q == amb_sel) begin
                state_d = ST_PRE_GREEN;
            end else if (state_q != ST_ALL_RED) begin
                state_d = ST_PRE_CLR;
            end else begin
                state_d = ST_PRE_ALLRED;
            end
        end else begin
            unique case (state_q)
                ST_ALL_RED: begin
                    if (timer_q == CNT_W'(ALL_RED_TIME - 1)) begin
                        state_d     = ST_GREEN;
                        timer_d     = '0;
                        active_d    = norm_next;
                        green_len_d = green_calc;
                    end
                end
                ST_GREEN: begin
                    if (timer_q == green_len_q - CNT_W'(1)) begin
                        state_d = ST_YELLOW;
                        timer_d = '0;
                    end
                end
                ST_YELLOW: begin
                    if (timer_q == CNT_W'(YELLOW_TIME - 1)) begin
                        state_d = ST_ALL_RED;
                        timer_d = '0;
                    end
                end
                ST_PRE_CLR: begin
                    if (timer_q == CNT_W'(PREEMPT_CLR - 1)) begin
                        state_d = ST_PRE_ALLRED;
                        timer_d = '0;
                    end
                end
                ST_PRE_ALLRED: begin
                    // exit_q separates the entry clearance from the exit one
                    if (timer_q == CNT_W'(ALL_RED_TIME - 1)) begin
                        timer_d = '0;
                        exit_d  = 1'b0;
                        if (!exit_q) begin
                            state_d  = ST_PRE_GREEN;
                            active_d = amb_idx_q;
                        end else if (amb_any) begin
                            state_d   = ST_PRE_GREEN;
                            amb_idx_d = amb_sel;
                            active_d  = amb_sel;
                        end else begin
                            state_d     = ST_GREEN;
                            emerg_d     = 1'b0;
                            active_d    = norm_next;
                            green_len_d = green_calc;
                        end
                    end
                end
                ST_PRE_GREEN: begin
                    timer_d = timer_q;
                    if (!bus.amb_req[amb_idx_q]) begin
                        state_d = ST_PRE_EXIT;
                        timer_d = '0;
                    end
                end
                ST_PRE_EXIT: begin
                    if (timer_q == CNT_W'(YELLOW_TIME - 1)) begin
                        state_d = ST_PRE_ALLRED;
                        timer_d = '0;
                        exit_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_ALL_RED;
                    timer_d = '0;
                end
            endcase
        end

        phase_start_d = (state_d != state_q) &&
                        (state_d == ST_GREEN || state_d == ST_PRE_GREEN);
    end

    // Output decode
    always_comb begin
        lights = '0;
        for (int unsigned i = 0; i < N_APPR; i++) begin
            lights[3*i +: 3] = LIGHT_RED;
            if (AW'(i) == active_q) begin
                if (is_green_state(state_q)) begin
                    lights[3*i +: 3] = LIGHT_GREEN;
                end else if (is_yellow_state(state_q)) begin
                    lights[3*i +: 3] = LIGHT_YELLOW;
                end
            end
        end
    end

    assign bus.lights         = lights;
    assign bus.active_appr    = active_q;
    assign bus.emergency_mode = emerg_q;
    assign bus.phase_start    = phase_start_q;

endmodule

// File: tb/tb_traffic_phase_controller_n.sv
// Scoreboard bench for traffic_phase_controller_n (N_APPR=4, default timing).
// The stimulus process pushes the expected per-cycle lamp/emergency/pulse
// picture into a queue; a monitor pops one entry per clock and compares.
module tb_traffic_phase_controller_n;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    typedef struct {
        logic [11:0] lights;
        logic        emerg;
        logic        ps;
        logic        chk_act;
        logic [1:0]  act;
    } exp_t;

    logic clk;
    logic rst_a;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec;
    int   n_err;

    traffic_phase_controller_n_if #(.N_APPR(4), .DENS_W(4)) tb_if ();

    traffic_phase_controller_n #(
        .N_APPR       (4),
        .DENS_W       (4),
        .CNT_W        (6),
        .MIN_GREEN    (4),
        .MAX_GREEN    (12),
        .YELLOW_TIME  (4),
        .ALL_RED_TIME (2),
        .PREEMPT_CLR  (3),
        .SKIP_EMPTY   (1)
    ) dut (
        .clk   (clk),
        .rst_a (rst_a),
        .bus   (tb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Push n cycles where approach appr (or none if appr < 0) shows colour c
    task automatic push_seg(input int appr, input logic [2:0] c, input int n,
                            input logic em, input logic ps_first);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.lights  = {R, R, R, R};
            e.chk_act = 1'b0;
            e.act     = 2'd0;
            if (appr >= 0) begin
                e.lights[3*appr +: 3] = c;
                e.chk_act = 1'b1;
                e.act     = 2'(appr);
            end
            e.emerg = em;
            e.ps    = ps_first && (i == 0);
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (sb.size() == 0) return;
        end
        check_eq("drain_timeout", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    // Reset for three clocks (checking reset values), release, expect one
    // remaining all-red cycle before the first green.
    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        rst_a = 1'b1;
        tb_if.amb_req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            e.lights  = {R, R, R, R};
            e.emerg   = 1'b0;
            e.ps      = 1'b0;
            e.chk_act = 1'b1;
            e.act     = 2'd3;
            sb.push_back(e);
        end
        drain();
        rst_a = 1'b0;
        push_seg(-1, R, 1, 1'b0, 1'b0);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check_eq("lights", 32'(tb_if.lights), 32'(mon_e.lights));
            check_eq("emergency_mode", 32'(tb_if.emergency_mode), 32'(mon_e.emerg));
            check_eq("phase_start", 32'(tb_if.phase_start), 32'(mon_e.ps));
            if (mon_e.chk_act) check_eq("active_appr", 32'(tb_if.active_appr), 32'(mon_e.act));
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_a = 1'b1;
        tb_if.amb_req = 4'b0000;
        tb_if.density = {4'd0, 4'd8, 4'd0, 4'd15};

        // Demand on 0 (d=15 -> 12) and 2 (d=8 -> 8); 1 and 3 skipped
        do_reset();
        push_seg(0, G, 12, 1'b0, 1'b1);
        push_seg(0, Y, 4, 1'b0, 1'b0);
        push_seg(-1, R, 2, 1'b0, 1'b0);
        push_seg(2, G, 8, 1'b0, 1'b1);
        push_seg(2, Y, 4, 1'b0, 1'b0);
        push_seg(-1, R, 2, 1'b0, 1'b0);
        push_seg(0, G, 12, 1'b0, 1'b1);
        push_seg(0, Y, 4, 1'b0, 1'b0);
        push_seg(-1, R, 2, 1'b0, 1'b0);
        push_seg(2, G, 3, 1'b0, 1'b1);
        drain();

        // No demand anywhere: plain round robin with minimum green
        tb_if.density = '0;
        do_reset();
        for (int a = 0; a < 4; a++) begin
            push_seg(a, G, 4, 1'b0, 1'b1);
            push_seg(a, Y, 4, 1'b0, 1'b0);
            push_seg(-1, R, 2, 1'b0, 1'b0);
        end
        push_seg(0, G, 2, 1'b0, 1'b1);
        drain();

        // Preemption to approach 2 during approach 0 green (after 5 cycles)
        tb_if.density = {4'd0, 4'd8, 4'd0, 4'd15};
        do_reset();
        push_seg(0, G, 5, 1'b0, 1'b1);
        drain();
        tb_if.amb_req = 4'b0100;
        push_seg(0, Y, 3, 1'b1, 1'b0);
        push_seg(-1, R, 2, 1'b1, 1'b0);
        push_seg(2, G, 15, 1'b1, 1'b1);
        drain();
        tb_if.amb_req = 4'b0000;
        push_seg(2, Y, 4, 1'b1, 1'b0);
        push_seg(-1, R, 2, 1'b1, 1'b0);
        push_seg(0, G, 12, 1'b0, 1'b1);
        push_seg(0, Y, 4, 1'b0, 1'b0);
        push_seg(-1, R, 2, 1'b0, 1'b0);
        push_seg(2, G, 2, 1'b0, 1'b1);
        drain();

        // Request on the approach already green: no interruption
        do_reset();
        push_seg(0, G, 3, 1'b0, 1'b1);
        drain();
        tb_if.amb_req = 4'b0001;
        push_seg(0, G, 10, 1'b1, 1'b1);
        drain();
        tb_if.amb_req = 4'b0000;
        push_seg(0, Y, 4, 1'b1, 1'b0);
        push_seg(-1, R, 2, 1'b1, 1'b0);
        push_seg(2, G, 8, 1'b0, 1'b1);
        push_seg(2, Y, 2, 1'b0, 1'b0);
        drain();

        // Simultaneous requests 1 and 3: lowest first, then hand over to 3
        do_reset();
        push_seg(0, G, 2, 1'b0, 1'b1);
        drain();
        tb_if.amb_req = 4'b1010;
        push_seg(0, Y, 3, 1'b1, 1'b0);
        push_seg(-1, R, 2, 1'b1, 1'b0);
        push_seg(1, G, 5, 1'b1, 1'b1);
        drain();
        tb_if.amb_req = 4'b1000;
        push_seg(1, Y, 4, 1'b1, 1'b0);
        push_seg(-1, R, 2, 1'b1, 1'b0);
        push_seg(3, G, 5, 1'b1, 1'b1);
        drain();
        tb_if.amb_req = 4'b0000;
        push_seg(3, Y, 4, 1'b1, 1'b0);
        push_seg(-1, R, 2, 1'b1, 1'b0);
        push_seg(0, G, 3, 1'b0, 1'b1);
        drain();

        // Reset asserted while approach 2 holds preemption green
        do_reset();
        push_seg(0, G, 2, 1'b0, 1'b1);
        drain();
        tb_if.amb_req = 4'b0100;
        push_seg(0, Y, 3, 1'b1, 1'b0);
        push_seg(-1, R, 2, 1'b1, 1'b0);
        push_seg(2, G, 3, 1'b1, 1'b1);
        drain();
        do_reset();
        push_seg(0, G, 3, 1'b0, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
